// File: rtl/subreg_hw_wr_sched_if.sv
// subreg_hw_wr_sched_if: SW/HW write requests in, register-bank strobes and status out
interface subreg_hw_wr_sched_if #(
  parameter int NumReq  = 4,
  parameter int NumRegs = 8,
  parameter int DW      = 32,
  parameter int CntW    = 8
);
  localparam int AW = $clog2(NumRegs);
  logic                 sw_we_i;
  logic [AW-1:0]        sw_addr_i;
  logic [DW-1:0]        sw_wd_i;
  logic [NumReq-1:0]    hw_req_i;
  logic [NumReq*AW-1:0] hw_addr_i;
  logic [NumReq*DW-1:0] hw_d_i;
  logic                 defer_cnt_clr_i;
  logic [NumReq-1:0]    hw_gnt_o;
  logic [NumRegs-1:0]   reg_we_o;
  logic [DW-1:0]        reg_wd_o;
  logic [NumRegs-1:0]   reg_de_o;
  logic [DW-1:0]        reg_d_o;
  logic                 addr_err_o;
  logic [CntW-1:0]      defer_cnt_o;
  modport slave (
    input  sw_we_i, sw_addr_i, sw_wd_i, hw_req_i, hw_addr_i, hw_d_i, defer_cnt_clr_i,
    output hw_gnt_o, reg_we_o, reg_wd_o, reg_de_o, reg_d_o, addr_err_o, defer_cnt_o
  );
  modport master (
    output sw_we_i, sw_addr_i, sw_wd_i, hw_req_i, hw_addr_i, hw_d_i, defer_cnt_clr_i,
    input  hw_gnt_o, reg_we_o, reg_wd_o, reg_de_o, reg_d_o, addr_err_o, defer_cnt_o
  );
endinterface

// File: rtl/subreg_hw_wr_sched.sv
// subreg_hw_wr_sched: round-robin HW write scheduler sharing one issue stage with SW writes
module subreg_hw_wr_sched #(
  parameter int NumReq  = 4,
  parameter int NumRegs = 8,
  parameter int DW      = 32,
  parameter int CntW    = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  subreg_hw_wr_sched_if.slave  io
);
  localparam int AW = $clog2(NumRegs);
  localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;
  logic [PW-1:0]      r_ptr, w_gidx, w_nptr;
  logic               w_found, w_defer, w_err;
  logic [NumReq-1:0]  w_elig;
  int                 w_idx;
  logic [AW-1:0]      w_haddr;
  logic [DW-1:0]      w_hd;
  logic [NumRegs-1:0] w_we, w_de, r_we, r_de;
  logic [DW-1:0]      r_wd, r_d;
  logic               r_err;
  logic [CntW-1:0]    r_cnt;
  // a HW requester yields to a same-cycle SW write aimed at the same register
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumReq; i++)
      w_elig[i] = io.hw_req_i[i] && !(io.sw_we_i && io.hw_addr_i[i*AW +: AW] == io.sw_addr_i);
  end
  // first eligible requester at or above the round-robin pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < NumReq; k++) begin
      w_idx = (int'(r_ptr) + k) % NumReq;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = PW'(w_idx);
      end
    end
  end
  assign w_defer     = |(io.hw_req_i & ~w_elig);
  assign w_haddr     = io.hw_addr_i[w_gidx*AW +: AW];
  assign w_hd        = io.hw_d_i[w_gidx*DW +: DW];
  assign w_nptr      = (w_gidx == PW'(NumReq - 1)) ? '0 : w_gidx + 1'b1;
  assign io.hw_gnt_o = w_found ? (NumReq'(1) << w_gidx) : '0;
  // one-hot slice decode; out-of-range indices decode to no strobe at all
  always_comb begin
    w_we = '0;
    w_de = '0;
    for (int j = 0; j < NumRegs; j++) begin
      w_we[j] = io.sw_we_i && io.sw_addr_i == AW'(j);
      w_de[j] = w_found && w_haddr == AW'(j);
    end
  end
  assign w_err = (io.sw_we_i && ({1'b0, io.sw_addr_i} >= (AW+1)'(NumRegs))) ||
                 (w_found && ({1'b0, w_haddr} >= (AW+1)'(NumRegs)));
  // issue stage: strobes pulse one cycle after acceptance, data holds between writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_we  <= '0;
      r_de  <= '0;
      r_wd  <= '0;
      r_d   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_ptr <= w_found ? w_nptr : r_ptr;
      r_we  <= w_we;
      r_de  <= w_de;
      r_wd  <= |w_we ? io.sw_wd_i : r_wd;
      r_d   <= |w_de ? w_hd : r_d;
      r_err <= w_err;
      r_cnt <= io.defer_cnt_clr_i ? '0 : (w_defer && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign io.reg_we_o    = r_we;
  assign io.reg_wd_o    = r_wd;
  assign io.reg_de_o    = r_de;
  assign io.reg_d_o     = r_d;
  assign io.addr_err_o  = r_err;
  assign io.defer_cnt_o = r_cnt;
endmodule

// File: tb/tb_subreg_hw_wr_sched.sv
// tb_subreg_hw_wr_sched: directed vector table for the HW/SW write scheduler
module tb_subreg_hw_wr_sched;
  localparam int NQ = 4, NR = 6, DW = 32, CW = 2;
  localparam logic [11:0] A0123 = 12'b011_010_001_000;
  typedef struct {
    logic        rst, sw_we;
    logic [2:0]  sw_a;
    logic [31:0] sw_wd;
    logic [3:0]  req;
    logic [11:0] ha;
    logic [31:0] hd0;
    logic        clr;
    logic [3:0]  gnt;
    logic [5:0]  we, de;
    logic [31:0] d, wd;
    logic        err;
    logic [1:0]  cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0, n_fail = 0;
  vec_t tbl[$];
  subreg_hw_wr_sched_if #(.NumReq(NQ), .NumRegs(NR), .DW(DW), .CntW(CW)) io ();
  subreg_hw_wr_sched #(.NumReq(NQ), .NumRegs(NR), .DW(DW), .CntW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .io(io.slave)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic swe, logic [2:0] sa, logic [31:0] swd, logic [3:0] rq,
                             logic [11:0] ha, logic [31:0] hd0, logic clr, logic [3:0] gnt,
                             logic [5:0] we, logic [5:0] de, logic [31:0] d, logic [31:0] wd,
                             logic err, logic [1:0] cnt);
    vec_t t;
    t.rst = r; t.sw_we = swe; t.sw_a = sa; t.sw_wd = swd; t.req = rq; t.ha = ha; t.hd0 = hd0;
    t.clr = clr; t.gnt = gnt; t.we = we; t.de = de; t.d = d; t.wd = wd; t.err = err; t.cnt = cnt;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(vec_t t, string tag);
    rst = t.rst;
    io.sw_we_i = t.sw_we;
    io.sw_addr_i = t.sw_a;
    io.sw_wd_i = t.sw_wd;
    io.hw_req_i = t.req;
    io.hw_addr_i = t.ha;
    io.defer_cnt_clr_i = t.clr;
    for (int i = 0; i < NQ; i++) io.hw_d_i[i*DW +: DW] = t.hd0 + 32'(i);
    #1;
    chk({tag, " gnt"}, 32'(io.hw_gnt_o), 32'(t.gnt));
    @(posedge clk);
    #1;
    chk({tag, " we"}, 32'(io.reg_we_o), 32'(t.we));
    chk({tag, " de"}, 32'(io.reg_de_o), 32'(t.de));
    chk({tag, " d"}, io.reg_d_o, t.d);
    chk({tag, " wd"}, io.reg_wd_o, t.wd);
    chk({tag, " err"}, 32'(io.addr_err_o), 32'(t.err));
    chk({tag, " cnt"}, 32'(io.defer_cnt_o), 32'(t.cnt));
  endtask
  initial begin
    tbl.push_back(v(1, 0, 0, 0,     4'b0000, 0, 0, 0,         4'b0000, 6'b000000, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 100, 0,   4'b0001, 6'b000000, 6'b000001, 100, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 100, 0,   4'b0010, 6'b000000, 6'b000010, 101, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 100, 0,   4'b0100, 6'b000000, 6'b000100, 102, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 100, 0,   4'b1000, 6'b000000, 6'b001000, 103, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 100, 0,   4'b0001, 6'b000000, 6'b000001, 100, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 'h55,  4'b0010, 12'b000_000_011_000, 200, 0, 4'b0000, 6'b001000, 6'b000000, 100, 'h55, 0, 1));
    tbl.push_back(v(0, 1, 3, 'h66,  4'b0010, 12'b000_000_011_000, 200, 0, 4'b0000, 6'b001000, 6'b000000, 100, 'h66, 0, 2));
    tbl.push_back(v(0, 0, 0, 0,     4'b0010, 12'b000_000_011_000, 200, 0, 4'b0010, 6'b000000, 6'b001000, 201, 'h66, 0, 2));
    tbl.push_back(v(0, 0, 0, 0,     4'b0000, 0, 0, 1,         4'b0000, 6'b000000, 6'b000000, 201, 'h66, 0, 0));
    tbl.push_back(v(0, 1, 2, 'h77,  4'b0001, 12'd5, 'hA5, 0,  4'b0001, 6'b000100, 6'b100000, 'hA5, 'h77, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b0001, 12'd7, 'h300, 0, 4'b0001, 6'b000000, 6'b000000, 'hA5, 'h77, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b0000, 0, 0, 0,         4'b0000, 6'b000000, 6'b000000, 'hA5, 'h77, 0, 0));
    tbl.push_back(v(0, 1, 6, 'h88,  4'b0000, 0, 0, 0,         4'b0000, 6'b000000, 6'b000000, 'hA5, 'h77, 1, 0));
    tbl.push_back(v(0, 1, 7, 'h99,  4'b0001, 12'd6, 'h310, 0, 4'b0001, 6'b000000, 6'b000000, 'hA5, 'h77, 1, 0));
    for (int c = 1; c <= 5; c++)
      tbl.push_back(v(0, 1, 1, 'h11, 4'b0011, 12'o0011, 'h320, 0, 4'b0000, 6'b000010, 6'b000000, 'hA5, 'h11, 0,
                      (c > 3) ? 2'd3 : 2'(c)));
    tbl.push_back(v(0, 1, 1, 'h11,  4'b0011, 12'o0011, 'h320, 1, 4'b0000, 6'b000010, 6'b000000, 'hA5, 'h11, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1010, 12'b011_000_001_000, 'h400, 0, 4'b0010, 6'b000000, 6'b000010, 'h401, 'h11, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1010, 12'b011_000_001_000, 'h400, 0, 4'b1000, 6'b000000, 6'b001000, 'h403, 'h11, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1010, 12'b011_000_001_000, 'h400, 0, 4'b0010, 6'b000000, 6'b000010, 'h401, 'h11, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,     4'b1111, A0123, 'h500, 0, 4'b0100, 6'b000000, 6'b000000, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,     4'b1111, A0123, 'h500, 0, 4'b0001, 6'b000000, 6'b000001, 'h500, 0, 0, 0));
    for (int n = 0; n < tbl.size(); n++) run(tbl[n], $sformatf("v%0d", n));
    run(v(0, 1, 2, 'h22, 4'b0001, 12'd2, 'h600, 0, 4'b0000, 6'b000100, 6'b000000, 'h500, 'h22, 0, 1), "defer");
    run(v(0, 0, 0, 0,    4'b0000, 12'd2, 'h600, 0, 4'b0000, 6'b000000, 6'b000000, 'h500, 'h22, 0, 1), "withdraw");
    run(v(0, 0, 0, 0,    4'b1111, A0123, 'h700, 0, 4'b0010, 6'b000000, 6'b000010, 'h701, 'h22, 0, 1), "resume");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
